// File: rtl/multicycle_conunit_if.sv
// Control/handshake bundle between the multi-cycle control unit and its datapath.
// The master side is the control unit; the slave side is the datapath and memory.
interface multicycle_conunit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       Op;
    logic [5:0]       Func;
    logic             Z;
    logic             Mrdy;
    logic             Mreq;
    logic             Iord;
    logic             IRwr;
    logic             Pcwr;
    logic [1:0]       Pcsrc;
    logic             Regrt;
    logic             Se;
    logic             Aluqb;
    logic [1:0]       Aluc;
    logic             Wreg;
    logic             Wmem;
    logic             Reg2reg;
    logic [2:0]       State;
    logic             Trap;
    logic [CNT_W-1:0] Icount;

    modport master (
        input  Op, Func, Z, Mrdy,
        output Mreq, Iord, IRwr, Pcwr, Pcsrc, Regrt, Se, Aluqb, Aluc,
        output Wreg, Wmem, Reg2reg, State, Trap, Icount
    );

    modport slave (
        output Op, Func, Z, Mrdy,
        input  Mreq, Iord, IRwr, Pcwr, Pcsrc, Regrt, Se, Aluqb, Aluc,
        input  Wreg, Wmem, Reg2reg, State, Trap, Icount
    );
endinterface

// File: rtl/multicycle_conunit.sv
// Multi-cycle MIPS-subset control FSM: IF/ID/EX/MEM/WB sequencing with a memory
// request/ready handshake, a retired-instruction counter and a sticky illegal-opcode trap.
module multicycle_conunit #(
    parameter int unsigned CNT_W = 32
) (
    input logic                 Clk,
    input logic                 Clr,
    multicycle_conunit_if.master bus
);
    localparam logic [2:0] StIf   = 3'd0;
    localparam logic [2:0] StId   = 3'd1;
    localparam logic [2:0] StEx   = 3'd2;
    localparam logic [2:0] StMem  = 3'd3;
    localparam logic [2:0] StWb   = 3'd4;
    localparam logic [2:0] StTrap = 3'd7;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpAndi = 6'b001100;
    localparam logic [5:0] OpOri  = 6'b001101;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;

    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;

    logic [2:0]       state_q, state_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] icount_q, icount_d;

    logic is_r, r_add, r_sub, r_and, r_or, r_ok;
    logic is_j, is_beq, is_bne, is_br, is_addi, is_andi, is_ori, is_lw, is_sw, is_mem;
    logic legal, taken;
    logic mreq, iord, irwr, pcwr, wreg, wmem;
    logic [1:0] pcsrc, aluc;

    assign is_r    = (bus.Op == OpR);
    assign r_add   = is_r && (bus.Func == FnAdd);
    assign r_sub   = is_r && (bus.Func == FnSub);
    assign r_and   = is_r && (bus.Func == FnAnd);
    assign r_or    = is_r && (bus.Func == FnOr);
    assign r_ok    = r_add || r_sub || r_and || r_or;
    assign is_j    = (bus.Op == OpJ);
    assign is_beq  = (bus.Op == OpBeq);
    assign is_bne  = (bus.Op == OpBne);
    assign is_br   = is_beq || is_bne;
    assign is_addi = (bus.Op == OpAddi);
    assign is_andi = (bus.Op == OpAndi);
    assign is_ori  = (bus.Op == OpOri);
    assign is_lw   = (bus.Op == OpLw);
    assign is_sw   = (bus.Op == OpSw);
    assign is_mem  = is_lw || is_sw;
    assign legal   = r_ok || is_addi || is_andi || is_ori || is_mem || is_br;
    assign taken   = (is_beq && bus.Z) || (is_bne && !bus.Z);

    always_comb begin
        aluc = 2'b00;
        if (r_sub || is_br)        aluc = 2'b01;
        else if (r_and || is_andi) aluc = 2'b10;
        else if (r_or || is_ori)   aluc = 2'b11;
    end

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        mreq    = 1'b0;
        iord    = 1'b0;
        irwr    = 1'b0;
        pcwr    = 1'b0;
        pcsrc   = 2'b00;
        wreg    = 1'b0;
        wmem    = 1'b0;
        case (state_q)
            StIf: begin
                mreq = 1'b1;
                if (bus.Mrdy) begin
                    irwr    = 1'b1;
                    state_d = StId;
                end
            end
            StId: begin
                if (is_j) begin
                    pcwr    = 1'b1;
                    pcsrc   = 2'b11;
                    state_d = StIf;
                end else if (!legal) begin
                    trap_d  = 1'b1;
                    state_d = StTrap;
                end else begin
                    state_d = StEx;
                end
            end
            StEx: begin
                if (is_br) begin
                    pcwr    = 1'b1;
                    pcsrc   = taken ? 2'b10 : 2'b00;
                    state_d = StIf;
                end else if (is_mem) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                // Wmem is held for the whole access so the memory sees a stable request.
                mreq = 1'b1;
                iord = 1'b1;
                wmem = is_sw;
                if (bus.Mrdy) begin
                    if (is_sw) begin
                        pcwr    = 1'b1;
                        state_d = StIf;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                wreg    = 1'b1;
                pcwr    = 1'b1;
                state_d = StIf;
            end
            StTrap: ;
            default: state_d = StIf;
        endcase
    end

    // Retirement coincides exactly with the PC write.
    assign icount_d = icount_q + (pcwr ? CNT_W'(1) : '0);

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q  <= StIf;
            trap_q   <= 1'b0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            trap_q   <= trap_d;
            icount_q <= icount_d;
        end
    end

    // Write strobes are forced low while reset is held.
    assign bus.Mreq    = mreq;
    assign bus.Iord    = iord;
    assign bus.IRwr    = irwr && !Clr;
    assign bus.Pcwr    = pcwr && !Clr;
    assign bus.Pcsrc   = pcsrc;
    assign bus.Wreg    = wreg && !Clr;
    assign bus.Wmem    = wmem && !Clr;
    assign bus.Regrt   = !is_r;
    assign bus.Se      = !(is_andi || is_ori);
    assign bus.Aluqb   = is_r || is_br;
    assign bus.Aluc    = aluc;
    assign bus.Reg2reg = !is_lw;
    assign bus.State   = state_q;
    assign bus.Trap    = trap_q;
    assign bus.Icount  = icount_q;
endmodule

// File: tb/tb_multicycle_conunit.sv
// Directed bench for multicycle_conunit: walks hand-built instruction sequences and
// compares every checked output against hand-computed values.
module tb_multicycle_conunit;
    logic Clk = 1'b0;
    logic Clr = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    multicycle_conunit_if #(.CNT_W(32)) bus ();

    multicycle_conunit #(.CNT_W(32)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negative edge; outputs then reflect the state entered at posedge.
    task automatic nx();
        @(negedge Clk);
    endtask

    initial begin
        bus.Op = 6'b000000; bus.Func = 6'b100000; bus.Z = 1'b0; bus.Mrdy = 1'b1;

        // Reset: strobes low even though IF with Mrdy=1 would load IR
        nx(); nx(); #1;
        chk("rst_state", 32'(bus.State), 32'd0);
        chk("rst_trap", 32'(bus.Trap), 32'd0);
        chk("rst_icount", bus.Icount, 32'd0);
        chk("rst_irwr", 32'(bus.IRwr), 32'd0);
        chk("rst_pcwr", 32'(bus.Pcwr), 32'd0);
        chk("rst_mreq", 32'(bus.Mreq), 32'd1);

        // add $3=$1+$2
        nx(); Clr = 1'b0; #1;
        chk("add_if_state", 32'(bus.State), 32'd0);
        chk("add_if_irwr", 32'(bus.IRwr), 32'd1);
        chk("add_if_iord", 32'(bus.Iord), 32'd0);
        nx(); #1;
        chk("add_id_state", 32'(bus.State), 32'd1);
        chk("add_id_pcwr", 32'(bus.Pcwr), 32'd0);
        nx(); #1;
        chk("add_ex_state", 32'(bus.State), 32'd2);
        chk("add_ex_regrt", 32'(bus.Regrt), 32'd0);
        chk("add_ex_aluc", 32'(bus.Aluc), 32'd0);
        chk("add_ex_aluqb", 32'(bus.Aluqb), 32'd1);
        nx(); #1;
        chk("add_wb_state", 32'(bus.State), 32'd4);
        chk("add_wb_wreg", 32'(bus.Wreg), 32'd1);
        chk("add_wb_pcwr", 32'(bus.Pcwr), 32'd1);
        chk("add_wb_pcsrc", 32'(bus.Pcsrc), 32'd0);
        chk("add_wb_reg2reg", 32'(bus.Reg2reg), 32'd1);

        // lw with three MEM wait cycles: 8 cycles total
        nx(); bus.Op = 6'b100011; #1;
        chk("lw_if_state", 32'(bus.State), 32'd0);
        chk("add_icount", bus.Icount, 32'd1);
        nx(); #1;
        chk("lw_id_state", 32'(bus.State), 32'd1);
        nx(); #1;
        chk("lw_ex_state", 32'(bus.State), 32'd2);
        chk("lw_ex_aluc", 32'(bus.Aluc), 32'd0);
        chk("lw_ex_aluqb", 32'(bus.Aluqb), 32'd0);
        chk("lw_ex_se", 32'(bus.Se), 32'd1);
        for (int i = 0; i < 3; i++) begin
            nx(); bus.Mrdy = 1'b0; #1;
            chk("lw_memwait_state", 32'(bus.State), 32'd3);
            chk("lw_memwait_mreq", 32'(bus.Mreq), 32'd1);
            chk("lw_memwait_iord", 32'(bus.Iord), 32'd1);
            chk("lw_memwait_wreg", 32'(bus.Wreg), 32'd0);
            chk("lw_memwait_pcwr", 32'(bus.Pcwr), 32'd0);
        end
        nx(); bus.Mrdy = 1'b1; #1;
        chk("lw_mem_state", 32'(bus.State), 32'd3);
        chk("lw_mem_wmem", 32'(bus.Wmem), 32'd0);
        chk("lw_mem_pcwr", 32'(bus.Pcwr), 32'd0);
        nx(); #1;
        chk("lw_wb_state", 32'(bus.State), 32'd4);
        chk("lw_wb_reg2reg", 32'(bus.Reg2reg), 32'd0);
        chk("lw_wb_regrt", 32'(bus.Regrt), 32'd1);
        chk("lw_wb_wreg", 32'(bus.Wreg), 32'd1);

        // beq taken
        nx(); bus.Op = 6'b000100; bus.Z = 1'b1; #1;
        chk("lw_icount", bus.Icount, 32'd2);
        nx(); #1;
        nx(); #1;
        chk("beqt_ex_state", 32'(bus.State), 32'd2);
        chk("beqt_ex_pcwr", 32'(bus.Pcwr), 32'd1);
        chk("beqt_ex_pcsrc", 32'(bus.Pcsrc), 32'd2);
        chk("beqt_ex_aluc", 32'(bus.Aluc), 32'd1);
        // beq not taken
        nx(); bus.Z = 1'b0; #1;
        chk("beqn_if_state", 32'(bus.State), 32'd0);
        chk("beqt_icount", bus.Icount, 32'd3);
        nx(); nx(); #1;
        chk("beqn_ex_pcwr", 32'(bus.Pcwr), 32'd1);
        chk("beqn_ex_pcsrc", 32'(bus.Pcsrc), 32'd0);
        // bne with Z=0 -> taken
        nx(); bus.Op = 6'b000101; #1;
        nx(); nx(); #1;
        chk("bne_ex_state", 32'(bus.State), 32'd2);
        chk("bne_ex_pcsrc", 32'(bus.Pcsrc), 32'd2);
        chk("bne_ex_wreg", 32'(bus.Wreg), 32'd0);

        // sw then j
        nx(); bus.Op = 6'b101011; #1;
        chk("bne_icount", bus.Icount, 32'd5);
        nx(); #1;
        chk("sw_id_wreg", 32'(bus.Wreg), 32'd0);
        nx(); #1;
        chk("sw_ex_state", 32'(bus.State), 32'd2);
        chk("sw_ex_wmem", 32'(bus.Wmem), 32'd0);
        nx(); #1;
        chk("sw_mem_state", 32'(bus.State), 32'd3);
        chk("sw_mem_wmem", 32'(bus.Wmem), 32'd1);
        chk("sw_mem_mreq", 32'(bus.Mreq), 32'd1);
        chk("sw_mem_wreg", 32'(bus.Wreg), 32'd0);
        chk("sw_mem_pcwr", 32'(bus.Pcwr), 32'd1);
        nx(); bus.Op = 6'b000010; #1;
        chk("j_if_state", 32'(bus.State), 32'd0);
        nx(); #1;
        chk("j_id_state", 32'(bus.State), 32'd1);
        chk("j_id_pcwr", 32'(bus.Pcwr), 32'd1);
        chk("j_id_pcsrc", 32'(bus.Pcsrc), 32'd3);

        // ori with one IF stall
        nx(); bus.Op = 6'b001101; bus.Mrdy = 1'b0; #1;
        chk("swj_icount", bus.Icount, 32'd7);
        chk("ori_ifwait_irwr", 32'(bus.IRwr), 32'd0);
        nx(); bus.Mrdy = 1'b1; #1;
        chk("ori_ifwait_state", 32'(bus.State), 32'd0);
        chk("ori_if_irwr", 32'(bus.IRwr), 32'd1);
        nx(); nx(); #1;
        chk("ori_ex_se", 32'(bus.Se), 32'd0);
        chk("ori_ex_aluc", 32'(bus.Aluc), 32'd3);
        chk("ori_ex_regrt", 32'(bus.Regrt), 32'd1);
        nx(); #1;
        chk("ori_wb_state", 32'(bus.State), 32'd4);

        // Illegal opcode: trap and hold
        nx(); bus.Op = 6'b111111; #1;
        nx(); #1;
        chk("ill_id_state", 32'(bus.State), 32'd1);
        for (int i = 0; i < 10; i++) begin
            nx(); #1;
            chk("trap_state", 32'(bus.State), 32'd7);
            chk("trap_flag", 32'(bus.Trap), 32'd1);
            chk("trap_mreq", 32'(bus.Mreq), 32'd0);
            chk("trap_strobes", {28'd0, bus.IRwr, bus.Pcwr, bus.Wreg, bus.Wmem}, 32'd0);
            chk("trap_icount", bus.Icount, 32'd8);
        end
        nx(); Clr = 1'b1; #1;
        chk("trapclr_state", 32'(bus.State), 32'd0);
        chk("trapclr_trap", 32'(bus.Trap), 32'd0);
        chk("trapclr_icount", bus.Icount, 32'd0);

        // j to get a nonzero count, then lw interrupted by reset during MEM wait
        nx(); Clr = 1'b0; bus.Op = 6'b000010; #1;
        nx(); #1;
        chk("j2_id_pcsrc", 32'(bus.Pcsrc), 32'd3);
        nx(); bus.Op = 6'b100011; #1;
        chk("j2_icount", bus.Icount, 32'd1);
        nx(); nx(); nx(); bus.Mrdy = 1'b0; #1;
        chk("lw2_memwait_state", 32'(bus.State), 32'd3);
        #2 Clr = 1'b1; #1;
        chk("aclr_state", 32'(bus.State), 32'd0);
        chk("aclr_icount", bus.Icount, 32'd0);
        chk("aclr_mreq", 32'(bus.Mreq), 32'd1);
        chk("aclr_iord", 32'(bus.Iord), 32'd0);
        chk("aclr_wreg", 32'(bus.Wreg), 32'd0);
        bus.Mrdy = 1'b1;
        nx(); #1;
        chk("aclr_hold_state", 32'(bus.State), 32'd0);
        chk("aclr_hold_irwr", 32'(bus.IRwr), 32'd0);
        Clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_conunit.md
Name: multicycle_conunit

Overview:
Control FSM that sequences a multi-cycle implementation of the team's MIPS-subset datapath: one shared ALU, a shared memory port, and an instruction register (IR). It decodes Op/Func from the IR and walks each instruction through IF/ID/EX/MEM/WB. It drives the same control signals as the single-cycle control unit, plus per-state write enables and a memory request/ready handshake. It also counts retired instructions and traps on illegal opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter Icount

Ports:
Clk  in  1  clock, rising edge
Clr  in  1  asynchronous reset, active-high
Op  in  6  IR[31:26]
Func  in  6  IR[5:0]
Z  in  1  ALU zero flag (valid in EX)
Mrdy  in  1  memory ready; completes the current Mreq access this cycle
Mreq  out  1  memory access request (IF fetch or MEM data)
Iord  out  1  0 = address from PC (fetch), 1 = address from ALU result register
IRwr  out  1  load IR
Pcwr  out  1  load PC from Pcsrc mux
Pcsrc  out  2  00 PC+4, 10 branch target, 11 jump target
Regrt  out  1  1 = write rt, 0 = write rd
Se  out  1  1 sign-extend, 0 zero-extend immediate
Aluqb  out  1  1 = ALU B from register, 0 = from immediate
Aluc  out  2  00 add, 01 sub, 10 and, 11 or
Wreg  out  1  register file write
Wmem  out  1  memory write qualifier (valid with Mreq)
Reg2reg  out  1  1 = write back ALU result, 0 = memory data
State  out  3  current state encoding
Trap  out  1  sticky illegal-instruction flag
Icount  out  CNT_W  retired instruction count

Behaviour:
- Clock and reset: single clock Clk; reset Clr is asynchronous, active-high.
- Reset values: State=IF(0), Trap=0, Icount=0. All strobes (Mreq excepted per state, IRwr, Pcwr, Wreg, Wmem) are 0 while Clr is high.
- Registered and combinational parts:
  - State, Trap and Icount are registered.
  - All other outputs are combinational from State, Op, Func, Z and Mrdy.
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=7.
- Instruction decode:
  - R-type (Op=000000): Func 100000 add, 100010 sub, 100100 and, 100101 or.
  - Immediate: addi 001000, andi 001100, ori 001101.
  - Memory: lw 100011, sw 101011.
  - Branch: beq 000100, bne 000101.
  - Jump: j 000010.
- IF: Mreq=1, Iord=0. Hold in IF while Mrdy=0. When Mrdy=1: IRwr=1, go to ID.
- ID (IR now valid):
  - j: Pcwr=1, Pcsrc=11, retire, go to IF.
  - Any undefined Op, or undefined Func with Op=0: go to TRAP, set Trap.
  - Otherwise go to EX.
- EX (all control outputs decoded from IR):
  - Regrt=0 for R-type, 1 otherwise.
  - Aluqb=1 for R-type/beq/bne, 0 otherwise.
  - Se=0 for andi/ori, 1 otherwise.
  - Aluc: add for addi/lw/sw, sub for sub/beq/bne, and for and/andi, or for or/ori.
  - beq/bne: Pcwr=1. Pcsrc=10 if taken (beq&Z or bne&!Z), else 00. Retire, go to IF.
  - lw/sw: go to MEM. ALU-type: go to WB.
- MEM: Mreq=1, Iord=1, Wmem=1 for sw (held stable while waiting). Hold while Mrdy=0. When Mrdy=1:
  - sw: Pcwr=1, Pcsrc=00, retire, go to IF.
  - lw: go to WB.
- WB: Wreg=1, Pcwr=1, Pcsrc=00, go to IF, retire.
  - Reg2reg=0 for lw, 1 otherwise.
  - Regrt as in EX.
- Latency with Mrdy tied 1:
  - j: 2 cycles.
  - beq/bne: 3 cycles.
  - R-type/imm/sw: 4 cycles.
  - lw: 5 cycles.
  - Each Mrdy=0 cycle adds one.
- Retire: Icount increments by 1 in the same cycle Pcwr=1. It wraps modulo 2^CNT_W.
- Invariant: Pcwr, Wreg and IRwr are each asserted at most once per instruction. Wreg and Wmem are never both 1.
- TRAP: all strobes 0, Mreq=0, state held until Clr. The trapping instruction is not counted.
- Clr asserted mid-instruction (including a MEM wait): immediate return to IF, no write strobes, Icount=0. The memory controller must drop the outstanding access when Mreq falls.
- Mrdy outside IF/MEM: ignored.

Test Plan:
- Reset, Mrdy=1, IR sequence add($3=$1+$2) -> states 0,1,2,4; Wreg=1 and Pcwr=1 with Pcsrc=00 in WB, Regrt=0, Aluc=00; Icount=1 after 4 cycles.
- lw with Mrdy low for 3 cycles in MEM -> State holds 3 for 3 cycles, Mreq=1, Iord=1, Wreg=0; then WB with Reg2reg=0, Regrt=1; total 8 cycles.
- beq with Z=1 -> Pcwr=1, Pcsrc=10 in EX. beq with Z=0 -> Pcsrc=00. bne with Z=0 -> Pcsrc=10. Each retires in 3 cycles.
- sw then j -> sw: Wmem=1 with Mreq in MEM, Wreg never 1. j: Pcsrc=11 in ID. Icount=2 after 6 cycles.
- Op=111111 -> State=7, Trap=1, all strobes 0 for 10 cycles, Icount unchanged; Clr pulse -> State=0, Trap=0.
- Clr asserted asynchronously during MEM wait of lw -> State=0, Mreq returns to fetch, Icount=0, no Wreg pulse observed.
